// File: rtl/mem_access_stage.sv
// RV64 memory-access stage: issues loads/stores over a req/ready/rvalid port,
// aligns and extends load data, and registers the result bundle for write-back.
module mem_access_stage #(
    parameter int XLEN = 64,
    parameter int BE_W = XLEN / 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [31:0]     i_instruction,
    input  logic            i_mem_read,
    input  logic            i_mem_write,
    input  logic            i_reg_write,
    input  logic            i_mem_to_reg,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [BE_W-1:0] o_dmem_be,
    input  logic            i_dmem_ready,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic [XLEN-1:0] o_alu_result,
    output logic [XLEN-1:0] o_mem_data,
    output logic [31:0]     o_instruction,
    output logic            o_reg_write,
    output logic            o_mem_to_reg,
    output logic            o_valid,
    output logic            o_mem_fault,
    output logic            o_busy
);

    localparam int LANE_W = $clog2(BE_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [XLEN-1:0]   r_alu_result;
    logic [31:0]       r_instruction;
    logic              r_reg_write;
    logic              r_mem_to_reg;
    logic              r_we;
    logic [XLEN-1:0]   r_wdata;
    logic [BE_W-1:0]   r_be;
    logic [XLEN-1:0]   r_buf_data;

    logic [2:0]        w_funct3;
    logic [LANE_W-1:0] w_lane;
    logic              w_mem_op;
    logic              w_misaligned;
    logic              w_fault;
    logic              w_start;
    logic              w_complete;
    logic              w_to_out;
    logic [BE_W-1:0]   w_size_mask;

    logic [2:0]        w_cap_funct3;
    logic [LANE_W-1:0] w_cap_lane;
    logic [XLEN-1:0]   w_rshift;
    logic [XLEN-1:0]   w_load_data;
    logic [XLEN-1:0]   w_result_data;

    // ------------------------------------------------------------------
    // Decode of the incoming bundle
    // ------------------------------------------------------------------
    assign w_funct3 = i_instruction[14:12];
    assign w_lane   = i_alu_result[LANE_W-1:0];
    assign w_mem_op = i_mem_read | i_mem_write;

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_misaligned = 1'b0;
        w_size_mask  = '0;
        case (w_funct3[1:0])
            2'b00: begin
                w_size_mask  = BE_W'(8'h01);
            end
            2'b01: begin
                w_size_mask  = BE_W'(8'h03);
                w_misaligned = w_lane[0];
            end
            2'b10: begin
                w_size_mask  = BE_W'(8'h0F);
                w_misaligned = |w_lane[1:0];
            end
            default: begin
                w_size_mask  = BE_W'(8'hFF);
                w_misaligned = |w_lane;
            end
        endcase
    end

    assign w_fault = (i_mem_read & i_mem_write)
                   | (i_mem_read & (w_funct3 == 3'b111))
                   | (i_mem_write & w_funct3[2])
                   | (w_mem_op & w_misaligned);

    assign w_start = (r_state == ST_IDLE) & i_valid & (i_mem_read ^ i_mem_write)
                   & ~w_fault & ~i_stall;

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_dmem_ready) begin
                    if (r_we) begin
                        w_complete  = 1'b1;
                        w_state_nxt = i_stall ? ST_DONE : ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (i_dmem_rvalid) begin
                    w_complete  = 1'b1;
                    w_state_nxt = i_stall ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!i_stall) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_to_out = ~i_stall & (w_complete | (r_state == ST_DONE));
    assign o_busy   = w_start | ((r_state != ST_IDLE) & ~w_to_out);

    // ------------------------------------------------------------------
    // Captured request; drives the memory port for the whole transaction
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_alu_result  <= '0;
            r_instruction <= '0;
            r_reg_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_be          <= '0;
        end else if (w_start) begin
            r_alu_result  <= i_alu_result;
            r_instruction <= i_instruction;
            r_reg_write   <= i_reg_write;
            r_mem_to_reg  <= i_mem_to_reg;
            r_we          <= i_mem_write;
            r_wdata       <= i_mem_write ? (i_rs2_data << {w_lane, 3'b000}) : '0;
            r_be          <= w_size_mask << w_lane;
        end
    end

    assign o_dmem_req   = (r_state == ST_REQ);
    assign o_dmem_we    = r_we;
    assign o_dmem_addr  = {r_alu_result[XLEN-1:LANE_W], {LANE_W{1'b0}}};
    assign o_dmem_wdata = r_wdata;
    assign o_dmem_be    = r_be;

    // ------------------------------------------------------------------
    // Load alignment and extension
    // ------------------------------------------------------------------
    assign w_cap_funct3 = r_instruction[14:12];
    assign w_cap_lane   = r_alu_result[LANE_W-1:0];
    assign w_rshift     = i_dmem_rdata >> {w_cap_lane, 3'b000};

    always_comb begin
        w_load_data = '0;
        case (w_cap_funct3)
            3'b000:  w_load_data = {{(XLEN-8){w_rshift[7]}}, w_rshift[7:0]};
            3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_rshift[7:0]};
            3'b001:  w_load_data = {{(XLEN-16){w_rshift[15]}}, w_rshift[15:0]};
            3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_rshift[15:0]};
            3'b010:  w_load_data = {{(XLEN-32){w_rshift[31]}}, w_rshift[31:0]};
            3'b110:  w_load_data = {{(XLEN-32){1'b0}}, w_rshift[31:0]};
            3'b011:  w_load_data = w_rshift;
            default: w_load_data = '0;
        endcase
    end

    assign w_result_data = r_we ? '0 : w_load_data;

    // A result completing under stall parks here until the output frees up.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_buf_data <= '0;
        end else if (w_complete && i_stall) begin
            r_buf_data <= w_result_data;
        end
    end

    // ------------------------------------------------------------------
    // Output register toward write-back
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid       <= 1'b0;
            o_alu_result  <= '0;
            o_mem_data    <= '0;
            o_instruction <= '0;
            o_reg_write   <= 1'b0;
            o_mem_to_reg  <= 1'b0;
            o_mem_fault   <= 1'b0;
        end else if (!i_stall) begin
            if (w_to_out) begin
                o_valid       <= 1'b1;
                o_alu_result  <= r_alu_result;
                o_mem_data    <= (r_state == ST_DONE) ? r_buf_data : w_result_data;
                o_instruction <= r_instruction;
                o_reg_write   <= r_reg_write;
                o_mem_to_reg  <= r_mem_to_reg;
                o_mem_fault   <= 1'b0;
            end else if ((r_state == ST_IDLE) && i_valid && !w_start) begin
                // Non-memory op or faulting access: single-cycle pass-through.
                o_valid       <= 1'b1;
                o_alu_result  <= i_alu_result;
                o_mem_data    <= '0;
                o_instruction <= i_instruction;
                o_reg_write   <= i_reg_write & ~w_fault;
                o_mem_to_reg  <= i_mem_to_reg;
                o_mem_fault   <= w_fault;
            end else begin
                o_valid       <= 1'b0;
                o_alu_result  <= '0;
                o_mem_data    <= '0;
                o_instruction <= '0;
                o_reg_write   <= 1'b0;
                o_mem_to_reg  <= 1'b0;
                o_mem_fault   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed latency/corner cases, then
// randomized traffic scored against a transaction-level reference model.
module tb_mem_access_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_stall;
    logic        i_valid;
    logic [63:0] i_alu_result;
    logic [63:0] i_rs2_data;
    logic [31:0] i_instruction;
    logic        i_mem_read;
    logic        i_mem_write;
    logic        i_reg_write;
    logic        i_mem_to_reg;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [63:0] o_dmem_addr;
    logic [63:0] o_dmem_wdata;
    logic [7:0]  o_dmem_be;
    logic        i_dmem_ready;
    logic        i_dmem_rvalid;
    logic [63:0] i_dmem_rdata;
    logic [63:0] o_alu_result;
    logic [63:0] o_mem_data;
    logic [31:0] o_instruction;
    logic        o_reg_write;
    logic        o_mem_to_reg;
    logic        o_valid;
    logic        o_mem_fault;
    logic        o_busy;

    always #5 i_clk = ~i_clk;

    mem_access_stage dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_stall       (i_stall),
        .i_valid       (i_valid),
        .i_alu_result  (i_alu_result),
        .i_rs2_data    (i_rs2_data),
        .i_instruction (i_instruction),
        .i_mem_read    (i_mem_read),
        .i_mem_write   (i_mem_write),
        .i_reg_write   (i_reg_write),
        .i_mem_to_reg  (i_mem_to_reg),
        .o_dmem_req    (o_dmem_req),
        .o_dmem_we     (o_dmem_we),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_wdata  (o_dmem_wdata),
        .o_dmem_be     (o_dmem_be),
        .i_dmem_ready  (i_dmem_ready),
        .i_dmem_rvalid (i_dmem_rvalid),
        .i_dmem_rdata  (i_dmem_rdata),
        .o_alu_result  (o_alu_result),
        .o_mem_data    (o_mem_data),
        .o_instruction (o_instruction),
        .o_reg_write   (o_reg_write),
        .o_mem_to_reg  (o_mem_to_reg),
        .o_valid       (o_valid),
        .o_mem_fault   (o_mem_fault),
        .o_busy        (o_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] alu;
        logic [31:0] instr;
        logic        rw;
        logic        m2r;
        logic        fault;
        logic [63:0] mdata;
    } exp_out_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [7:0]  be;
        logic        we;
    } exp_req_t;

    exp_out_t out_q[$];
    exp_req_t req_q[$];

    function automatic int size_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic is_fault(input logic rd, input logic wr, input logic [2:0] f3,
                                      input logic [63:0] a);
        if (rd && wr) return 1'b1;
        if (rd && f3 == 3'b111) return 1'b1;
        if (wr && f3[2]) return 1'b1;
        if ((rd || wr) && (int'(a[2:0]) % size_bytes(f3)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] load_value(input logic [63:0] rdata, input logic [2:0] lane,
                                               input logic [2:0] f3);
        int          nbytes = size_bytes(f3);
        logic [63:0] v      = rdata >> (8 * lane);
        logic [63:0] mask;
        if (nbytes == 8) return v;
        mask = (64'd1 << (8 * nbytes)) - 64'd1;
        v = v & mask;
        if (!f3[2] && v[8 * nbytes - 1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_op(input logic v, input logic [63:0] alu, input logic [63:0] rs2,
                          input logic [2:0] f3, input logic rd, input logic wr,
                          input logic rw, input logic m2r);
        i_valid       = v;
        i_alu_result  = alu;
        i_rs2_data    = rs2;
        i_instruction = 32'h00A0_0283;
        i_instruction[14:12] = f3;
        i_mem_read    = rd;
        i_mem_write   = wr;
        i_reg_write   = rw;
        i_mem_to_reg  = m2r;
    endtask

    task automatic cyc();
        @(posedge i_clk);
        @(negedge i_clk);
        #1;
    endtask

    task automatic do_load(input string tag, input logic [63:0] addr, input logic [2:0] f3,
                           input logic [63:0] rdata, input logic [63:0] exp);
        set_op(1'b1, addr, 64'h0, f3, 1'b1, 1'b0, 1'b1, 1'b1);
        i_dmem_ready  = 1'b1;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = rdata;
        #1;
        check({tag, "_busy_c0"}, o_busy, 1);
        cyc();
        check({tag, "_req_c1"}, o_dmem_req, 1);
        check({tag, "_addr"}, o_dmem_addr, {addr[63:3], 3'b000});
        check({tag, "_we"}, o_dmem_we, 0);
        check({tag, "_busy_c1"}, o_busy, 1);
        cyc();
        check({tag, "_busy_c2"}, o_busy, 0);
        check({tag, "_valid_c2"}, o_valid, 0);
        set_op(1'b0, 64'h0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        check({tag, "_valid_c3"}, o_valid, 1);
        check({tag, "_data"}, o_mem_data, exp);
        check({tag, "_rw"}, o_reg_write, 1);
        i_dmem_ready  = 1'b0;
        i_dmem_rvalid = 1'b0;
    endtask

    // ---------------- random-phase state ----------------
    int          n_ops;
    logic        adv;
    logic        prev_stall, prev_req, prev_ready, prev_rvalid;
    logic        rv_pending;
    int          rv_wait;
    logic [63:0] rv_rdata;

    initial begin
        exp_out_t    e;
        exp_req_t    r;
        logic [2:0]  f3;
        logic [63:0] alu, rs2, rdata;
        logic        rd, wr, flt;
        logic [15:0] be_t;
        int          kind;

        i_rst = 1'b1;
        i_stall = 1'b0;
        i_dmem_ready = 1'b0;
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata = 64'h0;
        set_op(1'b0, 64'h0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        cyc();
        cyc();
        i_rst = 1'b0;
        check("rst_valid", o_valid, 0);
        check("rst_alu", o_alu_result, 0);
        check("rst_rw", o_reg_write, 0);
        check("rst_req", o_dmem_req, 0);
        check("rst_busy", o_busy, 0);

        // ALU op: single-cycle, never busy
        set_op(1'b1, 64'h1234, 64'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("alu_busy", o_busy, 0);
        cyc();
        set_op(1'b0, 64'h0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("alu_valid", o_valid, 1);
        check("alu_result", o_alu_result, 64'h1234);
        check("alu_rw", o_reg_write, 1);
        check("alu_mdata", o_mem_data, 0);
        check("alu_req", o_dmem_req, 0);

        do_load("lb", 64'h1003, 3'b000, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lbu", 64'h1003, 3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
        do_load("lh", 64'h1006, 3'b001, 64'h8123_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8123);
        do_load("lwu", 64'h1004, 3'b110, 64'hF000_0000_1234_5678, 64'h0000_0000_F000_0000);

        // SH at 2006
        set_op(1'b1, 64'h2006, 64'hBEEF, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
        i_dmem_ready = 1'b1;
        #1;
        check("sh_busy_c0", o_busy, 1);
        cyc();
        check("sh_req", o_dmem_req, 1);
        check("sh_addr", o_dmem_addr, 64'h2000);
        check("sh_be", o_dmem_be, 8'hC0);
        check("sh_wdata", o_dmem_wdata, 64'hBEEF_0000_0000_0000);
        check("sh_we", o_dmem_we, 1);
        check("sh_busy_c1", o_busy, 0);
        set_op(1'b0, 64'h0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        check("sh_valid_c2", o_valid, 1);
        check("sh_fault", o_mem_fault, 0);
        i_dmem_ready = 1'b0;

        // Misaligned LW
        set_op(1'b1, 64'h1002, 64'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        check("lw_mis_busy", o_busy, 0);
        cyc();
        check("lw_mis_valid", o_valid, 1);
        check("lw_mis_fault", o_mem_fault, 1);
        check("lw_mis_rw", o_reg_write, 0);
        check("lw_mis_req", o_dmem_req, 0);
        set_op(1'b0, 64'h0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        check("lw_mis_req2", o_dmem_req, 0);
        check("lw_mis_bubble_fault", o_mem_fault, 0);

        // LD with slow memory and stall across completion
        set_op(1'b1, 64'h3008, 64'h0, 3'b011, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc();
        for (int k = 0; k < 3; k++) begin
            check("ld_req_wait", o_dmem_req, 1);
            cyc();
        end
        i_dmem_ready = 1'b1;
        #1;
        check("ld_req_acc", o_dmem_req, 1);
        cyc();
        i_dmem_ready = 1'b0;
        i_stall = 1'b1;
        check("ld_resp_req", o_dmem_req, 0);
        cyc();
        cyc();
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata = 64'hDEAD_BEEF_0123_4567;
        #1;
        check("ld_cmpl_busy", o_busy, 1);
        cyc();
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
        #1;
        check("ld_done_valid", o_valid, 0);
        check("ld_done_busy", o_busy, 1);
        cyc();
        i_stall = 1'b0;
        #1;
        check("ld_rel_busy", o_busy, 0);
        check("ld_rel_valid", o_valid, 0);
        set_op(1'b0, 64'h0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        check("ld_out_valid", o_valid, 1);
        check("ld_out_data", o_mem_data, 64'hDEAD_BEEF_0123_4567);

        // Reset while REQ is pending
        set_op(1'b1, 64'h4000, 64'h0, 3'b011, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc();
        check("rstq_req", o_dmem_req, 1);
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        check("rstq_req_drop", o_dmem_req, 0);

        // Reset in RESP, then stray rvalid
        i_dmem_ready = 1'b1;
        cyc();
        i_dmem_ready = 1'b0;
        set_op(1'b0, 64'h0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        check("rstp_valid", o_valid, 0);
        check("rstp_alu", o_alu_result, 0);
        check("rstp_mdata", o_mem_data, 0);
        check("rstp_req", o_dmem_req, 0);
        check("rstp_addr", o_dmem_addr, 0);
        check("rstp_be", o_dmem_be, 0);
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata = 64'hFFFF_0000_FFFF_0000;
        #1;
        check("rstp_stray_busy", o_busy, 0);
        cyc();
        i_dmem_rvalid = 1'b0;
        check("rstp_stray_valid", o_valid, 0);
        check("rstp_stray_mdata", o_mem_data, 0);
        set_op(1'b1, 64'h5555, 64'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("rstp_alu_busy", o_busy, 0);
        cyc();
        check("rstp_alu_valid", o_valid, 1);
        check("rstp_alu_res", o_alu_result, 64'h5555);

        // ---------------- randomized traffic ----------------
        set_op(1'b0, 64'h0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        n_ops = 0;
        adv = 1'b1;
        prev_stall = 1'b1;
        prev_req = 1'b0;
        prev_ready = 1'b0;
        prev_rvalid = 1'b0;
        rv_pending = 1'b0;
        rv_wait = 0;
        rv_rdata = 64'h0;

        for (int c = 0; c < 8000 && (n_ops < 300 || out_q.size() != 0); c++) begin
            if (prev_req && prev_ready && req_q.size() != 0) begin
                r = req_q.pop_front();
                if (!r.we) begin
                    rv_pending = 1'b1;
                    rv_rdata = r.rdata;
                    rv_wait = $urandom_range(0, 2);
                end
            end
            if (prev_rvalid) rv_pending = 1'b0;

            if (!prev_stall) begin
                if (o_valid) begin
                    if (out_q.size() == 0) begin
                        check("rnd_extra_valid", o_valid, 0);
                    end else begin
                        e = out_q.pop_front();
                        check("rnd_alu", o_alu_result, e.alu);
                        check("rnd_instr", 64'(o_instruction), 64'(e.instr));
                        check("rnd_rw", o_reg_write, e.rw);
                        check("rnd_m2r", o_mem_to_reg, e.m2r);
                        check("rnd_fault", o_mem_fault, e.fault);
                        check("rnd_mdata", o_mem_data, e.mdata);
                    end
                end else begin
                    check("rnd_bubble_rw", o_reg_write, 0);
                end
            end

            if (o_dmem_req) begin
                if (req_q.size() == 0) begin
                    check("rnd_extra_req", o_dmem_req, 0);
                end else begin
                    check("rnd_req_addr", o_dmem_addr, req_q[0].addr);
                    check("rnd_req_we", o_dmem_we, req_q[0].we);
                    if (req_q[0].we) begin
                        check("rnd_req_be", o_dmem_be, req_q[0].be);
                        check("rnd_req_wdata", o_dmem_wdata, req_q[0].wdata);
                    end
                end
            end

            if (adv) begin
                if (n_ops >= 300) begin
                    set_op(1'b0, 64'h0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
                end else begin
                    n_ops++;
                    kind = $urandom_range(0, 9);
                    f3 = 3'($urandom_range(0, 7));
                    alu = {$urandom, $urandom};
                    rs2 = {$urandom, $urandom};
                    rdata = {$urandom, $urandom};
                    rd = (kind >= 1 && kind <= 4) || kind == 8;
                    wr = (kind >= 5 && kind <= 8);
                    if ($urandom_range(0, 3) != 0) alu = alu & ~64'(size_bytes(f3) - 1);
                    set_op(kind != 0, alu, rs2, f3, rd, wr, 1'($urandom), 1'($urandom));
                    i_instruction = $urandom;
                    i_instruction[14:12] = f3;
                    if (kind != 0) begin
                        flt = is_fault(rd, wr, f3, alu);
                        e.alu = alu;
                        e.instr = i_instruction;
                        e.rw = i_reg_write & ~flt;
                        e.m2r = i_mem_to_reg;
                        e.fault = flt;
                        e.mdata = (rd && !flt) ? load_value(rdata, alu[2:0], f3) : 64'h0;
                        out_q.push_back(e);
                        if (!flt && (rd || wr)) begin
                            be_t = ((16'd1 << size_bytes(f3)) - 16'd1) << alu[2:0];
                            r.addr = alu & ~64'h7;
                            r.we = wr;
                            r.be = be_t[7:0];
                            r.wdata = rs2 << (8 * alu[2:0]);
                            r.rdata = rdata;
                            req_q.push_back(r);
                        end
                    end
                end
            end

            i_stall = ($urandom_range(0, 4) == 0);
            i_dmem_ready = o_dmem_req && ($urandom_range(0, 2) != 0);
            if (rv_pending && rv_wait == 0) begin
                i_dmem_rvalid = 1'b1;
                i_dmem_rdata = rv_rdata;
            end else begin
                i_dmem_rvalid = 1'b0;
                i_dmem_rdata = {$urandom, $urandom};
                if (rv_pending) rv_wait--;
            end
            #1;
            adv = !o_busy && !i_stall;
            prev_stall = i_stall;
            prev_req = o_dmem_req;
            prev_ready = i_dmem_ready;
            prev_rvalid = i_dmem_rvalid;
            @(posedge i_clk);
            @(negedge i_clk);
        end

        check("rnd_drain_out", 64'(out_q.size()), 0);
        check("rnd_drain_req", 64'(req_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage of the RV64 pipeline, sitting directly upstream of the write-back stage.
- Takes execute results and control bits, and performs loads and stores against a single-ported data memory using a req/ready/rvalid handshake.
- Aligns and sign- or zero-extends load data.
- Presents a registered result bundle (alu_result, mem_data, instruction, reg_write, mem_to_reg) to write-back.
- Raises a busy stall toward upstream stages while a memory transaction is in flight.

Parameters:
- XLEN, 64, datapath and address width in bits.
- BE_W, 8, byte-enable width (XLEN/8).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_stall  in  1  downstream freeze; output register holds while high.
- i_valid  in  1  input bundle is valid this cycle.
- i_alu_result  in  64  effective address, or ALU result for non-memory ops.
- i_rs2_data  in  64  store data.
- i_instruction  in  32  instruction; funct3 is [14:12], rd is [11:7].
- i_mem_read  in  1  load.
- i_mem_write  in  1  store.
- i_reg_write  in  1  rd write enable.
- i_mem_to_reg  in  1  write-back selects mem_data.
- o_dmem_req  out  1  memory request.
- o_dmem_we  out  1  1 means store.
- o_dmem_addr  out  64  address with bits [2:0] forced to 0.
- o_dmem_wdata  out  64  lane-shifted store data.
- o_dmem_be  out  8  byte enables.
- i_dmem_ready  in  1  request accepted.
- i_dmem_rvalid  in  1  load data valid.
- i_dmem_rdata  in  64  load doubleword.
- o_alu_result  out  64  to write-back.
- o_mem_data  out  64  extended load data to write-back.
- o_instruction  out  32  to write-back.
- o_reg_write  out  1  to write-back.
- o_mem_to_reg  out  1  to write-back.
- o_valid  out  1  output bundle valid.
- o_mem_fault  out  1  misaligned address or illegal access on the current output.
- o_busy  out  1  stall request to upstream stages (combinational).

Behaviour:
- Reset (synchronous, i_rst high at posedge):
  - FSM goes to IDLE.
  - All outputs and the internal result buffer clear to 0; o_dmem_req deasserts the next cycle.
  - An in-flight transaction is abandoned, and any later i_dmem_rvalid seen in IDLE is ignored.
- FSM states:
  - IDLE: no transaction in flight.
  - REQ: o_dmem_req=1; address, wdata, be and we stay stable until i_dmem_ready.
  - RESP: waiting for i_dmem_rvalid.
  - DONE: result buffered, waiting for i_stall low.
- Start condition: IDLE, i_valid, exactly one of i_mem_read or i_mem_write set, no fault, and !i_stall.
  - Captures the inputs and goes to REQ.
  - o_busy = start || state != IDLE, except it drops in the cycle the result moves to the output register.
  - While busy, the output register presents a bubble: o_valid=0, o_reg_write=0.
- Non-memory op (IDLE, i_valid, neither read nor write, !i_stall): output register loads the bundle at the next edge, latency 1; o_mem_data=0.
- REQ state:
  - i_dmem_ready && store: transaction complete.
  - i_dmem_ready && load: go to RESP.
- RESP state: on i_dmem_rvalid, extract and extend data; transaction complete.
- Completion:
  - If !i_stall: output register loads the captured bundle with o_valid=1 and returns to IDLE at the same edge.
  - Otherwise: result goes to the buffer and the FSM goes to DONE.
  - DONE transfers to the output on the first cycle i_stall is low.
- Minimum latencies with ready and rvalid both asserted on the first eligible cycle:
  - Store: 2 cycles from start to o_valid.
  - Load: 3 cycles from start to o_valid.
- Load funct3, with lane = addr[2:0]:
  - 000 LB and 100 LBU: byte at lane, sign- or zero-extended.
  - 001 LH and 101 LHU: halfword at lane, sign- or zero-extended.
  - 010 LW and 110 LWU: word at lane, sign- or zero-extended.
  - 011 LD: full doubleword.
  - 111: fault.
- Store funct3:
  - 000 SB: be = 8'h01<<lane.
  - 001 SH: be = 8'h03<<lane.
  - 010 SW: be = 8'h0F<<lane.
  - 011 SD: be = 8'hFF.
  - 1xx: fault.
  - wdata = rs2 << (8*lane).
- Fault conditions:
  - Halfword access with addr[0]≠0.
  - Word access with addr[1:0]≠0.
  - Doubleword access with addr[2:0]≠0.
  - Illegal funct3.
  - Read and write both set.
- Fault response:
  - No memory request is issued, latency is 1 like a non-memory op.
  - o_mem_fault=1 and o_reg_write forced to 0 on that output.
- i_stall high in IDLE: output register and FSM hold; no start is taken.
- i_stall never aborts a REQ or RESP transaction.
- i_valid=0 in IDLE with !i_stall: output loads a bubble (o_valid=0, o_reg_write=0, o_mem_fault=0).

Test Plan:
- ALU op: i_alu_result=64'h1234, i_reg_write=1 -> next cycle o_valid=1, o_alu_result=64'h1234, o_busy never high.
- LB at addr 64'h1003, rdata=64'h0000_0000_8000_0000, ready and rvalid immediate -> o_busy high for 2 cycles, o_mem_data=64'hFFFF_FFFF_FFFF_FF80 3 cycles after start; the LBU variant gives 64'h80.
- SH at addr 64'h2006, rs2=64'hBEEF -> o_dmem_addr=64'h2000, be=8'hC0, wdata=64'hBEEF_0000_0000_0000, we=1; o_valid 2 cycles after start.
- LW at addr 64'h1002 -> o_mem_fault=1, o_reg_write=0, o_dmem_req stays 0.
- LD with ready delayed 3 cycles, rvalid delayed 2 more, i_stall high during RESP and the completion cycle -> FSM enters DONE, output updates on the first cycle i_stall is low, data = rdata.
- i_rst asserted in RESP, then rvalid arrives -> all outputs 0, o_dmem_req deasserts the next cycle, the stray rvalid is ignored, and the next ALU op completes normally.
